// File: rtl/bgpu_opc_pkg.sv
// Shared types, default widths and state encodings for the operand collector.
package bgpu_opc_pkg;

    localparam int NUM_TAGS          = 8;
    localparam int PC_WIDTH          = 32;
    localparam int NUM_WARPS         = 8;
    localparam int WARP_WIDTH        = 8;
    localparam int REG_IDX_WIDTH     = 6;
    localparam int OPERANDS_PER_INST = 3;
    localparam int REG_WIDTH         = 4;

    localparam int TAG_WIDTH  = $clog2(NUM_TAGS);
    localparam int WID_WIDTH  = $clog2(NUM_WARPS);
    localparam int IID_WIDTH  = TAG_WIDTH + WID_WIDTH;
    localparam int DATA_WIDTH = REG_WIDTH * WARP_WIDTH;

    typedef logic [IID_WIDTH-1:0]     iid_t;
    typedef logic [REG_IDX_WIDTH-1:0] reg_idx_t;
    typedef logic [WID_WIDTH-1:0]     wid_t;
    typedef logic [WARP_WIDTH-1:0]    act_mask_t;
    typedef logic [PC_WIDTH-1:0]      pc_t;
    typedef logic [DATA_WIDTH-1:0]    data_t;

    typedef enum logic {
        ENTRY_EMPTY,
        ENTRY_COLLECT
    } entry_state_e;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_REQ,
        SLOT_WAIT,
        SLOT_DONE
    } slot_state_e;

endpackage

// File: rtl/opc_operand_slot.sv
// One source-operand slot: issues a single register read, waits for the
// response and holds the returned data until the entry retires.
module opc_operand_slot
    import bgpu_opc_pkg::*;
#(
    parameter int RegIdxWidth = REG_IDX_WIDTH,
    parameter int DataWidth   = DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   start,
    input  logic [RegIdxWidth-1:0] start_reg_idx,
    input  logic                   clear,
    output logic                   req_valid,
    output logic [RegIdxWidth-1:0] req_reg_idx,
    input  logic                   req_ready,
    input  logic                   rsp_valid,
    input  logic [DataWidth-1:0]   rsp_data,
    output logic                   done,
    output logic [DataWidth-1:0]   data
);

    slot_state_e            state_reg;
    slot_state_e            state_next;
    logic [RegIdxWidth-1:0] reg_idx_reg;
    logic [DataWidth-1:0]   data_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= SLOT_IDLE;
            reg_idx_reg <= '0;
            data_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == SLOT_IDLE && start) begin
                reg_idx_reg <= start_reg_idx;
            end
            // Only a slot with an accepted request may capture; stray
            // responses in any other state leave the data untouched.
            if (state_reg == SLOT_WAIT && rsp_valid) begin
                data_reg <= rsp_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SLOT_IDLE: if (start)     state_next = SLOT_REQ;
            SLOT_REQ:  if (req_ready) state_next = SLOT_WAIT;
            SLOT_WAIT: if (rsp_valid) state_next = SLOT_DONE;
            SLOT_DONE: if (clear)     state_next = SLOT_IDLE;
            default:                  state_next = SLOT_IDLE;
        endcase
    end

    assign req_valid   = (state_reg == SLOT_REQ);
    assign req_reg_idx = reg_idx_reg;
    assign done        = (state_reg == SLOT_DONE);
    assign data        = data_reg;

endmodule

// File: rtl/bgpu_operand_collector.sv
// Single-entry operand collector: holds one dispatched instruction, gathers
// its source operands over per-operand read ports and hands it to the EU.
module bgpu_operand_collector
    import bgpu_opc_pkg::*;
#(
    parameter int NumTags         = NUM_TAGS,
    parameter int PcWidth         = PC_WIDTH,
    parameter int NumWarps        = NUM_WARPS,
    parameter int WarpWidth       = WARP_WIDTH,
    parameter int RegIdxWidth     = REG_IDX_WIDTH,
    parameter int OperandsPerInst = OPERANDS_PER_INST,
    parameter int RegWidth        = REG_WIDTH,
    localparam int TagWidth       = $clog2(NumTags),
    localparam int WidWidth       = $clog2(NumWarps),
    localparam int IidWidth       = TagWidth + WidWidth,
    localparam int DataWidth      = RegWidth * WarpWidth
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    output logic                                   opc_ready_o,
    input  logic                                   disp_valid_i,
    input  logic [IidWidth-1:0]                    disp_tag_i,
    input  logic [PcWidth-1:0]                     disp_pc_i,
    input  logic [WarpWidth-1:0]                   disp_act_mask_i,
    input  logic [RegIdxWidth-1:0]                 disp_dst_i,
    input  logic [OperandsPerInst*RegIdxWidth-1:0] disp_src_i,
    output logic [OperandsPerInst-1:0]             opc_read_req_valid_o,
    output logic [OperandsPerInst*WidWidth-1:0]    opc_read_req_wid_o,
    output logic [OperandsPerInst*RegIdxWidth-1:0] opc_read_req_reg_idx_o,
    input  logic [OperandsPerInst-1:0]             opc_read_req_ready_i,
    input  logic [OperandsPerInst-1:0]             opc_read_rsp_valid_i,
    input  logic [OperandsPerInst*DataWidth-1:0]   opc_read_rsp_data_i,
    input  logic                                   eu_ready_i,
    output logic                                   opc_valid_o,
    output logic [IidWidth-1:0]                    opc_tag_o,
    output logic [PcWidth-1:0]                     opc_pc_o,
    output logic [WarpWidth-1:0]                   opc_act_mask_o,
    output logic [RegIdxWidth-1:0]                 opc_dst_o,
    output logic [OperandsPerInst*DataWidth-1:0]   opc_operand_data_o
);

    entry_state_e               state_reg;
    entry_state_e               state_next;
    logic [IidWidth-1:0]        tag_reg;
    logic [PcWidth-1:0]         pc_reg;
    logic [WarpWidth-1:0]       mask_reg;
    logic [RegIdxWidth-1:0]     dst_reg;
    logic [OperandsPerInst-1:0] slot_done;
    logic                       insert;
    logic                       retire;
    logic                       all_done;

    assign all_done = &slot_done;
    assign insert   = (state_reg == ENTRY_EMPTY) && disp_valid_i;
    assign retire   = (state_reg == ENTRY_COLLECT) && all_done && eu_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ENTRY_EMPTY;
            tag_reg   <= '0;
            pc_reg    <= '0;
            mask_reg  <= '0;
            dst_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (insert) begin
                tag_reg  <= disp_tag_i;
                pc_reg   <= disp_pc_i;
                mask_reg <= disp_act_mask_i;
                dst_reg  <= disp_dst_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ENTRY_EMPTY:   if (insert) state_next = ENTRY_COLLECT;
            ENTRY_COLLECT: if (retire) state_next = ENTRY_EMPTY;
            default:                   state_next = ENTRY_EMPTY;
        endcase
    end

    // Every request carries the warp id held in the upper tag bits.
    genvar gi;
    generate
        for (gi = 0; gi < OperandsPerInst; gi++) begin : g_slot
            opc_operand_slot #(
                .RegIdxWidth (RegIdxWidth),
                .DataWidth   (DataWidth)
            ) u_slot (
                .clk           (clk_i),
                .srst          (rst_i),
                .start         (insert),
                .start_reg_idx (disp_src_i[gi*RegIdxWidth +: RegIdxWidth]),
                .clear         (retire),
                .req_valid     (opc_read_req_valid_o[gi]),
                .req_reg_idx   (opc_read_req_reg_idx_o[gi*RegIdxWidth +: RegIdxWidth]),
                .req_ready     (opc_read_req_ready_i[gi]),
                .rsp_valid     (opc_read_rsp_valid_i[gi]),
                .rsp_data      (opc_read_rsp_data_i[gi*DataWidth +: DataWidth]),
                .done          (slot_done[gi]),
                .data          (opc_operand_data_o[gi*DataWidth +: DataWidth])
            );
            assign opc_read_req_wid_o[gi*WidWidth +: WidWidth] = tag_reg[IidWidth-1:TagWidth];
        end
    endgenerate

    assign opc_ready_o    = (state_reg == ENTRY_EMPTY);
    assign opc_valid_o    = (state_reg == ENTRY_COLLECT) && all_done;
    assign opc_tag_o      = tag_reg;
    assign opc_pc_o       = pc_reg;
    assign opc_act_mask_o = mask_reg;
    assign opc_dst_o      = dst_reg;

endmodule

// File: tb/tb_bgpu_operand_collector.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and a randomized run against a transaction-level register-file model.
module tb_bgpu_operand_collector;

    localparam int OPS  = 3;
    localparam int RIW  = 6;
    localparam int WIDW = 3;
    localparam int IIDW = 6;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              opc_ready_o;
    logic              disp_valid_i;
    logic [IIDW-1:0]   disp_tag_i;
    logic [31:0]       disp_pc_i;
    logic [7:0]        disp_act_mask_i;
    logic [RIW-1:0]    disp_dst_i;
    logic [OPS*RIW-1:0] disp_src_i;
    logic [OPS-1:0]    opc_read_req_valid_o;
    logic [OPS*WIDW-1:0] opc_read_req_wid_o;
    logic [OPS*RIW-1:0] opc_read_req_reg_idx_o;
    logic [OPS-1:0]    opc_read_req_ready_i;
    logic [OPS-1:0]    opc_read_rsp_valid_i;
    logic [OPS*DW-1:0] opc_read_rsp_data_i;
    logic              eu_ready_i;
    logic              opc_valid_o;
    logic [IIDW-1:0]   opc_tag_o;
    logic [31:0]       opc_pc_o;
    logic [7:0]        opc_act_mask_o;
    logic [RIW-1:0]    opc_dst_o;
    logic [OPS*DW-1:0] opc_operand_data_o;

    always #5 clk = ~clk;

    bgpu_operand_collector dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .opc_ready_o            (opc_ready_o),
        .disp_valid_i           (disp_valid_i),
        .disp_tag_i             (disp_tag_i),
        .disp_pc_i              (disp_pc_i),
        .disp_act_mask_i        (disp_act_mask_i),
        .disp_dst_i             (disp_dst_i),
        .disp_src_i             (disp_src_i),
        .opc_read_req_valid_o   (opc_read_req_valid_o),
        .opc_read_req_wid_o     (opc_read_req_wid_o),
        .opc_read_req_reg_idx_o (opc_read_req_reg_idx_o),
        .opc_read_req_ready_i   (opc_read_req_ready_i),
        .opc_read_rsp_valid_i   (opc_read_rsp_valid_i),
        .opc_read_rsp_data_i    (opc_read_rsp_data_i),
        .eu_ready_i             (eu_ready_i),
        .opc_valid_o            (opc_valid_o),
        .opc_tag_o              (opc_tag_o),
        .opc_pc_o               (opc_pc_o),
        .opc_act_mask_o         (opc_act_mask_o),
        .opc_dst_o              (opc_dst_o),
        .opc_operand_data_o     (opc_operand_data_o)
    );

    typedef struct {
        logic [IIDW-1:0]    tag;
        logic [31:0]        pc;
        logic [7:0]         mask;
        logic [RIW-1:0]     dst;
        logic [OPS*RIW-1:0] src;
        logic [OPS*DW-1:0]  rsp;
        logic [WIDW-1:0]    exp_wid;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid_i         = 1'b0;
        disp_tag_i           = '0;
        disp_pc_i            = '0;
        disp_act_mask_i      = '0;
        disp_dst_i           = '0;
        disp_src_i           = '0;
        opc_read_req_ready_i = '0;
        opc_read_rsp_valid_i = '0;
        opc_read_rsp_data_i  = '0;
        eu_ready_i           = 1'b0;
    endtask

    task automatic drive_insert(input logic [IIDW-1:0] tag, input logic [31:0] pc,
                                input logic [7:0] mask, input logic [RIW-1:0] dst,
                                input logic [OPS*RIW-1:0] src);
        disp_valid_i    = 1'b1;
        disp_tag_i      = tag;
        disp_pc_i       = pc;
        disp_act_mask_i = mask;
        disp_dst_i      = dst;
        disp_src_i      = src;
    endtask

    task automatic check_fields(input string pfx, input logic [IIDW-1:0] tag, input logic [31:0] pc,
                                input logic [7:0] mask, input logic [RIW-1:0] dst);
        check({pfx, "_tag"},  opc_tag_o, tag);
        check({pfx, "_pc"},   opc_pc_o, pc);
        check({pfx, "_mask"}, opc_act_mask_o, mask);
        check({pfx, "_dst"},  opc_dst_o, dst);
    endtask

    // Immediate-ready flow: insert at N, requests at N+1, responses at N+2,
    // opc_valid at N+3. Leaves the bench in cycle N+3 with eu_ready low.
    task automatic run_to_valid(input vec_t v, input string pfx);
        check({pfx, "_ready_n"}, opc_ready_o, 1'b1);
        drive_insert(v.tag, v.pc, v.mask, v.dst, v.src);
        opc_read_req_ready_i = '1;
        step();
        disp_valid_i = 1'b0;
        check({pfx, "_reqv_n1"}, opc_read_req_valid_o, 3'b111);
        check({pfx, "_valid_n1"}, opc_valid_o, 1'b0);
        check({pfx, "_ready_n1"}, opc_ready_o, 1'b0);
        for (int i = 0; i < OPS; i++) begin
            check({pfx, "_wid"}, opc_read_req_wid_o[i*WIDW +: WIDW], v.exp_wid);
            check({pfx, "_regidx"}, opc_read_req_reg_idx_o[i*RIW +: RIW], v.src[i*RIW +: RIW]);
        end
        step();
        opc_read_req_ready_i = '0;
        check({pfx, "_reqv_n2"}, opc_read_req_valid_o, 3'b000);
        check({pfx, "_valid_n2"}, opc_valid_o, 1'b0);
        opc_read_rsp_valid_i = '1;
        opc_read_rsp_data_i  = v.rsp;
        step();
        opc_read_rsp_valid_i = '0;
        opc_read_rsp_data_i  = '0;
        check({pfx, "_valid_n3"}, opc_valid_o, 1'b1);
        check({pfx, "_data"}, opc_operand_data_o, v.rsp);
        check_fields(pfx, v.tag, v.pc, v.mask, v.dst);
    endtask

    task automatic retire_now(input string pfx);
        eu_ready_i = 1'b1;
        step();
        eu_ready_i = 1'b0;
        check({pfx, "_ready_after"}, opc_ready_o, 1'b1);
        check({pfx, "_valid_after"}, opc_valid_o, 1'b0);
    endtask

    vec_t vecs[4];
    vec_t v;

    // Reference-model state for the randomized run
    bit              have_inst;
    logic [IIDW-1:0] m_tag;
    logic [31:0]     m_pc;
    logic [7:0]      m_mask;
    logic [RIW-1:0]  m_dst;
    logic [RIW-1:0]  m_src [OPS];
    logic [DW-1:0]   m_data [OPS];
    int              m_acc [OPS];
    bit              m_pend [OPS];
    int              m_delay [OPS];
    bit              m_sent [OPS];

    initial begin
        vecs[0] = '{tag: 6'h2A, pc: 32'h1000_0040, mask: 8'hFF, dst: 6'd12,
                    src: {6'd9, 6'd7, 6'd3},
                    rsp: {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF}, exp_wid: 3'd5};
        vecs[1] = '{tag: 6'h07, pc: 32'h0000_0000, mask: 8'h01, dst: 6'd0,
                    src: {6'd63, 6'd0, 6'd63},
                    rsp: {32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF}, exp_wid: 3'd0};
        vecs[2] = '{tag: 6'h3F, pc: 32'hFFFF_FFFC, mask: 8'h80, dst: 6'd63,
                    src: {6'd4, 6'd2, 6'd1},
                    rsp: {32'hA5A5_5A5A, 32'h1111_2222, 32'h3333_4444}, exp_wid: 3'd7};
        vecs[3] = '{tag: 6'h18, pc: 32'h0000_1234, mask: 8'h5A, dst: 6'd33,
                    src: {6'd17, 6'd42, 6'd21},
                    rsp: {32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hCAFE_F00D}, exp_wid: 3'd3};

        idle_inputs();
        rst_i = 1'b1;
        step();
        step();
        check("rst_ready", opc_ready_o, 1'b1);
        check("rst_valid", opc_valid_o, 1'b0);
        check("rst_reqv", opc_read_req_valid_o, 3'b000);
        check("rst_data", opc_operand_data_o, '0);
        check("rst_tag", opc_tag_o, '0);
        rst_i = 1'b0;
        step();
        $display("[TB] reset: ready=%0b valid=%0b", opc_ready_o, opc_valid_o);

        // Directed table, immediate readiness and responses
        for (int k = 0; k < 4; k++) begin
            run_to_valid(vecs[k], "tbl");
            retire_now("tbl");
            $display("[TB] vector %0d tag=0x%0h wid=%0d done", k, vecs[k].tag, vecs[k].exp_wid);
        end

        // Out-of-order responses: operand 2, then 0, then 1
        v = vecs[0];
        drive_insert(v.tag, v.pc, v.mask, v.dst, v.src);
        opc_read_req_ready_i = '1;
        step();
        disp_valid_i = 1'b0;
        step();
        opc_read_req_ready_i = '0;
        opc_read_rsp_valid_i = 3'b100;
        opc_read_rsp_data_i  = v.rsp;
        step();
        check("ooo_valid_after_op2", opc_valid_o, 1'b0);
        opc_read_rsp_valid_i = 3'b001;
        step();
        check("ooo_valid_after_op0", opc_valid_o, 1'b0);
        opc_read_rsp_valid_i = 3'b010;
        step();
        opc_read_rsp_valid_i = '0;
        check("ooo_valid_after_op1", opc_valid_o, 1'b1);
        check("ooo_data", opc_operand_data_o, v.rsp);
        retire_now("ooo");
        $display("[TB] out-of-order responses sequence done");

        // EU stall for 10 cycles with a competing dispatch
        v = vecs[2];
        run_to_valid(v, "stall");
        for (int c = 0; c < 10; c++) begin
            drive_insert(6'h11, 32'h7777_7777, 8'h33, 6'd5, {6'd1, 6'd1, 6'd1});
            step();
            check("stall_valid", opc_valid_o, 1'b1);
            check("stall_ready", opc_ready_o, 1'b0);
            check("stall_data", opc_operand_data_o, v.rsp);
            check_fields("stall", v.tag, v.pc, v.mask, v.dst);
        end
        disp_valid_i = 1'b0;
        retire_now("stall");
        check("stall_tag_held_after", opc_tag_o, v.tag);
        $display("[TB] EU stall sequence done");

        // Responses while slots are IDLE, then while in REQ
        opc_read_rsp_valid_i = '1;
        opc_read_rsp_data_i  = {3{32'hBAD0_BAD0}};
        step();
        opc_read_rsp_valid_i = '0;
        check("idle_rsp_data", opc_operand_data_o, v.rsp);
        check("idle_rsp_valid", opc_valid_o, 1'b0);
        v = vecs[3];
        drive_insert(v.tag, v.pc, v.mask, v.dst, v.src);
        step();
        disp_valid_i = 1'b0;
        opc_read_rsp_valid_i = '1;
        opc_read_rsp_data_i  = {3{32'hBAD1_BAD1}};
        step();
        opc_read_rsp_valid_i = '0;
        check("req_hold_reqv", opc_read_req_valid_o, 3'b111);
        check("req_hold_regidx", opc_read_req_reg_idx_o, v.src);
        check("req_rsp_valid", opc_valid_o, 1'b0);
        opc_read_req_ready_i = '1;
        step();
        opc_read_req_ready_i = '0;
        opc_read_rsp_valid_i = '1;
        opc_read_rsp_data_i  = v.rsp;
        step();
        opc_read_rsp_valid_i = '0;
        check("req_rsp_final_valid", opc_valid_o, 1'b1);
        check("req_rsp_final_data", opc_operand_data_o, v.rsp);
        retire_now("req_rsp");
        $display("[TB] stray response sequence done");

        // Reset while waiting for responses
        v = vecs[1];
        drive_insert(v.tag, v.pc, v.mask, v.dst, v.src);
        opc_read_req_ready_i = '1;
        step();
        disp_valid_i = 1'b0;
        step();
        opc_read_req_ready_i = '0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        opc_read_rsp_valid_i = '1;
        opc_read_rsp_data_i  = {3{32'h1234_5678}};
        step();
        opc_read_rsp_valid_i = '0;
        check("midrst_ready", opc_ready_o, 1'b1);
        check("midrst_valid", opc_valid_o, 1'b0);
        check("midrst_reqv", opc_read_req_valid_o, 3'b000);
        check("midrst_data", opc_operand_data_o, '0);
        check("midrst_tag", opc_tag_o, '0);
        $display("[TB] mid-operation reset sequence done");

        // Randomized run against the register-file / EU model
        begin
            int  done_cnt = 0;
            int  cyc = 0;
            int  age = 0;
            bit  aborted = 1'b0;
            have_inst = 1'b0;
            for (int i = 0; i < OPS; i++) begin
                m_acc[i] = 0; m_pend[i] = 1'b0; m_sent[i] = 1'b0; m_delay[i] = 0;
            end
            while (done_cnt < 1000 && cyc < 60000 && !aborted) begin
                bit ins;
                bit ret;
                bit all_sent;
                bit acc [OPS];
                ins = 1'b0;
                ret = 1'b0;
                all_sent = 1'b1;
                for (int i = 0; i < OPS; i++) if (!m_sent[i]) all_sent = 1'b0;

                check("rand_ready", opc_ready_o, !have_inst);
                check("rand_valid", opc_valid_o, have_inst && all_sent);
                for (int i = 0; i < OPS; i++) begin
                    check("rand_reqv", opc_read_req_valid_o[i], have_inst && (m_acc[i] == 0));
                    if (opc_read_req_valid_o[i]) begin
                        check("rand_wid", opc_read_req_wid_o[i*WIDW +: WIDW], m_tag[IIDW-1 -: WIDW]);
                        check("rand_regidx", opc_read_req_reg_idx_o[i*RIW +: RIW], m_src[i]);
                    end
                end

                eu_ready_i = 1'($urandom_range(0, 1));
                if (opc_valid_o && eu_ready_i) begin
                    ret = 1'b1;
                    check_fields("rand", m_tag, m_pc, m_mask, m_dst);
                    for (int i = 0; i < OPS; i++)
                        check("rand_data", opc_operand_data_o[i*DW +: DW], m_data[i]);
                end

                disp_valid_i    = 1'($urandom_range(0, 1));
                disp_tag_i      = IIDW'($urandom);
                disp_pc_i       = $urandom;
                disp_act_mask_i = 8'($urandom);
                disp_dst_i      = RIW'($urandom);
                disp_src_i      = (OPS*RIW)'($urandom);
                if (!have_inst && disp_valid_i) begin
                    ins    = 1'b1;
                    m_tag  = disp_tag_i;
                    m_pc   = disp_pc_i;
                    m_mask = disp_act_mask_i;
                    m_dst  = disp_dst_i;
                    for (int i = 0; i < OPS; i++) m_src[i] = disp_src_i[i*RIW +: RIW];
                end

                for (int i = 0; i < OPS; i++) begin
                    opc_read_req_ready_i[i] = 1'($urandom_range(0, 1));
                    acc[i] = have_inst && opc_read_req_valid_o[i] && opc_read_req_ready_i[i];
                    opc_read_rsp_data_i[i*DW +: DW] = $urandom;
                    if (m_pend[i] && m_delay[i] == 0) begin
                        opc_read_rsp_valid_i[i] = 1'b1;
                        m_data[i] = opc_read_rsp_data_i[i*DW +: DW];
                        m_pend[i] = 1'b0;
                        m_sent[i] = 1'b1;
                    end else if (m_pend[i]) begin
                        opc_read_rsp_valid_i[i] = 1'b0;
                        m_delay[i]--;
                    end else begin
                        opc_read_rsp_valid_i[i] = ($urandom_range(0, 7) == 0);
                    end
                end

                step();
                cyc++;

                for (int i = 0; i < OPS; i++) begin
                    if (acc[i]) begin
                        m_acc[i]++;
                        m_pend[i]  = 1'b1;
                        m_delay[i] = $urandom_range(0, 3);
                    end
                end
                if (ret) begin
                    have_inst = 1'b0;
                    done_cnt++;
                    $display("[TB] random inst %0d tag=0x%0h pc=0x%0h retired", done_cnt, m_tag, m_pc);
                end
                if (ins) begin
                    have_inst = 1'b1;
                    age = 0;
                    for (int i = 0; i < OPS; i++) begin
                        m_acc[i] = 0; m_pend[i] = 1'b0; m_sent[i] = 1'b0;
                    end
                end
                if (have_inst) begin
                    age++;
                    if (age > 300) begin
                        tests++;
                        fails++;
                        $display("FAIL rand_deadlock: instruction held %0d cycles, required retire within 300", age);
                        aborted = 1'b1;
                    end
                end
            end
            idle_inputs();
            check("rand_count", done_cnt, 1000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
